// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, constants and the address legality check used
//                by the data-memory responder and its RAM array.
//                  dmem_state_t : responder FSM encoding (IDLE, WAIT, RESP)
//                  WORD_BYTES   : byte lanes per 32-bit word
//                  addr_ok()    : word alignment + in-range check
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Legal when word aligned and the full word index (addr[31:2]) lies below
  // depth. The whole upper field is compared, so large addresses never alias
  // back into the array.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word-addressed RAM with one synchronous byte-lane write port
//                and one combinational read port. Contents are not reset.
//  Ports       : clk      - clock, writes on rising edge
//                wr_en    - write strobe
//                wr_addr  - word index for the write
//                wr_data  - write data
//                wr_be    - per-lane write enables (lane i = bits 8i+7:8i)
//                rd_addr  - word index for the read
//                rd_data  - read data (current contents, before any write
//                           happening on the same edge)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [31:0]           rd_data
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory target for processor loads/stores. Accepts one
//                request at a time over a valid/ready channel, waits
//                WAIT_CYCLES, then presents the response on a valid/ready
//                channel. Misaligned or out-of-range accesses return
//                rsp_err=1 with zero data and never write.
//  Config      : DMEM_BYTE_WRITE_EN - when defined, adds req_be and stores
//                write only the enabled byte lanes; otherwise every store
//                writes the full word.
//  Ports       : clk        - clock
//                reset      - asynchronous reset, active low
//                req_valid  - request present
//                req_ready  - responder can accept a request (registered)
//                req_we     - 1 = store, 0 = load
//                req_addr   - byte address
//                req_wdata  - store data
//                req_be     - byte enables (DMEM_BYTE_WRITE_EN only)
//                rsp_valid  - response present
//                rsp_ready  - requester takes the response
//                rsp_rdata  - load data, 0 for stores and errors
//                rsp_err    - access was misaligned or out of range
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned c_ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_CYCLES);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  r_be;
`endif
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // --------------------------------------------------------------------------
  // Current transaction view
  // --------------------------------------------------------------------------
  // With zero wait states the commit edge is the accept edge itself, so the
  // live request fields are used while in IDLE and the captured copy after.
  logic                  w_accept;
  logic                  w_in_idle;
  logic                  w_cur_we;
  logic [31:0]           w_cur_addr;
  logic [31:0]           w_cur_wdata;
  logic [WORD_BYTES-1:0] w_cur_be;
  logic                  w_ok;
  logic                  w_enter_resp;
  logic                  w_wr_en;
  logic [c_ADDR_W-1:0]   w_index;
  logic [31:0]           w_rd_data;
  logic [31:0]           w_rsp_rdata;

  assign w_in_idle   = (r_state == IDLE);
  assign w_accept    = w_in_idle && req_valid && r_req_ready;

  assign w_cur_we    = w_in_idle ? req_we    : r_we;
  assign w_cur_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_cur_wdata = w_in_idle ? req_wdata : r_wdata;
`ifdef DMEM_BYTE_WRITE_EN
  assign w_cur_be    = w_in_idle ? req_be    : r_be;
`else
  assign w_cur_be    = '1;
`endif

  assign w_ok        = addr_ok(w_cur_addr, DEPTH);
  assign w_index     = w_cur_addr[c_ADDR_W+1:2];

  // The edge that moves the FSM into RESP is the commit edge for stores and
  // the sample edge for loads.
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_wr_en     = w_enter_resp && w_cur_we && w_ok;
  assign w_rsp_rdata = (!w_cur_we && w_ok) ? w_rd_data : 32'h0;

  // --------------------------------------------------------------------------
  // RAM
  // --------------------------------------------------------------------------
  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (w_index),
    .wr_data (w_cur_wdata),
    .wr_be   (w_cur_be),
    .rd_addr (w_index),
    .rd_data (w_rd_data)
  );

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
`ifdef DMEM_BYTE_WRITE_EN
      r_be        <= 4'h0;
`endif
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Ready rises on the first edge after reset release and stays up
          // until a request is taken.
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
            r_be        <= req_be;
`endif
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end
          end
        end

        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end

        RESP: begin
          // Response is held untouched until the requester takes it; ready
          // then returns on this edge so it is visible the following cycle.
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
        end
      endcase

      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rsp_rdata;
        r_rsp_err   <= !w_ok;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed bench for dmem_responder. Drives a WAIT_CYCLES=2
//                instance and, from the same request channel, a
//                WAIT_CYCLES=0 instance whose response is always taken.
//                Optional byte-enable cases run under DMEM_BYTE_WRITE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  localparam int unsigned c_WAIT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_ready0;
  logic        rsp_valid0;
  logic [31:0] rsp_rdata0;
  logic        rsp_err0;
  logic        rsp_ready0;

  int n_total;
  int n_bad;

  assign rsp_ready0 = 1'b1;

  dmem_responder #(
    .DEPTH       (1024),
    .WAIT_CYCLES (c_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(
    .DEPTH       (1024),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. Called #1 after a rising edge. Checks the
  // zero-wait instance right after the accept edge, the main instance's
  // latency, payload, optional stall stability and ready recovery.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input bit early_rdy, input int stall,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input logic [31:0] exp0_rdata);
    int edges;
    check_eq({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = early_rdy;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, ".w0_valid"}, {31'b0, rsp_valid0}, 32'd1);
    check_eq({tag, ".w0_rdata"}, rsp_rdata0, exp0_rdata);
    check_eq({tag, ".w0_err"},   {31'b0, rsp_err0}, {31'b0, exp_err});
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, ".latency"}, edges, c_WAIT + 1);
    check_eq({tag, ".busy_ready"}, {31'b0, req_ready}, 32'd0);
    check_eq({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    if (stall > 0) begin
      // A new request waits on the channel while the response is held off.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'd4092;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check_eq({tag, ".stall_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_eq({tag, ".stall_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, ".stall_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        check_eq({tag, ".stall_ready"}, {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, ".post_valid"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, ".post_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    rsp_ready = 1'b0;
    #2 reset  = 1'b0;

    // Reset held for three cycles: everything low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst.req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
      check_eq("rst.rsp_err",   {31'b0, rsp_err}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rel.req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rel.rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Seed known words, then store/load round trip.
    txn("st4092", 1'b1, 32'd4092, 32'hCAFEF00D, 4'hF, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("st0",    1'b1, 32'd0,    32'h12345678, 4'hF, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("st4036", 1'b1, 32'd4036, 32'd1024,     4'hF, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("ld4036", 1'b0, 32'd4036, 32'h0,        4'hF, 1'b0, 0, 32'd1024, 1'b0, 32'd1024);

    // Illegal accesses.
    txn("ld4038", 1'b0, 32'd4038, 32'h0,        4'hF, 1'b0, 0, 32'h0, 1'b1, 32'h0);
    txn("st4096", 1'b1, 32'd4096, 32'h55555555, 4'hF, 1'b0, 0, 32'h0, 1'b1, 32'h0);
    txn("ldhigh", 1'b0, 32'h80000004, 32'h0,    4'hF, 1'b0, 0, 32'h0, 1'b1, 32'h0);
    txn("ld4092", 1'b0, 32'd4092, 32'h0,        4'hF, 1'b1, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);

    // Response held off for five cycles.
    txn("stall",  1'b0, 32'd4036, 32'h0,        4'hF, 1'b0, 5, 32'd1024, 1'b0, 32'd1024);
    repeat (2) @(posedge clk);
    #1;

    // Reset during WAIT of a store: the main instance drops it, the
    // zero-wait instance has already committed it.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd0;
    req_wdata = 32'hDEADBEEF;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort.in_wait", {31'b0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("abort.req_ready", {31'b0, req_ready}, 32'd0);
    check_eq("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort.idle", {31'b0, req_ready}, 32'd1);
    txn("ld0",    1'b0, 32'd0,    32'h0,        4'hF, 1'b0, 0, 32'h12345678, 1'b0, 32'hDEADBEEF);

`ifdef DMEM_BYTE_WRITE_EN
    txn("be.full", 1'b1, 32'h100, 32'h11223344, 4'hF,    1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("be.0101", 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("be.ld1",  1'b0, 32'h100, 32'h0,        4'hF,    1'b0, 0, 32'h11BB33DD, 1'b0, 32'h11BB33DD);
    txn("be.none", 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0,    1'b0, 0, 32'h0, 1'b0, 32'h0);
    txn("be.ld2",  1'b0, 32'h100, 32'h0,        4'hF,    1'b0, 0, 32'h11BB33DD, 1'b0, 32'h11BB33DD);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
